uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares one UART serial transmit line among four byte requesters. Arbitrates round-robin, latches the winning byte, and serialises it as 8N1, LSB first. Bit timing comes from the 16x oversampling `Tick` produced by the UART baud-rate generator in the same clock domain. Sits between the baud generator and the board TX pin, replacing per-source transmitters.

## Interface
- `NREQ`, 4 – number of requesters; the RTL supports only 4 (2-bit owner index).
- `OVS`, 16 – `Tick` pulses per bit period.

Ports:
- `Clk`  in  1  system clock (100 MHz).
- `Rst_n`  in  1  reset, synchronous, active-low.
- `Tick`  in  1  one-`Clk`-wide pulse at 16x baud, from the baud generator.
- `En`  in  1  1 = new grants allowed; 0 = finish the current frame, then hold idle.
- `req`  in  4  per-requester level request; held until granted.
- `data`  in  32  byte for requester i on `data[8i+7:8i]`; must be valid while `req[i]`=1.
- `gnt`  out  4  one-hot, one-cycle pulse; byte accepted from that requester.
- `done`  out  4  one-hot, one-cycle pulse; that requester's stop bit has finished.
- `owner`  out  2  index of the current or last granted requester.
- `busy`  out  1  high from grant through the end of the stop bit.
- `TxD`  out  1  serial line; idles high.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: `TxD`=1, `busy`=0.
  - If `En`=1 and `req`≠0, pick the first set bit searching from `ptr`, wrapping 3→0.
  - On that clock edge: pulse `gnt[k]`, latch `data[8k+:8]` into the shift register, set `owner`=k, set `ptr`=k+1 mod 4, enter START.
- START: `TxD`=0.
- DATA: `TxD`=shift[0]. Shift right at each bit boundary. Leave after 8 bits (3-bit bit counter reaches 7).
- STOP: `TxD`=1. At the bit boundary: pulse `done[owner]` and return to IDLE.
- Bit boundary: a 4-bit tick counter is cleared on grant and increments on each `Tick` in START/DATA/STOP. The edge where the counter is 15 and `Tick`=1 ends the bit and wraps the counter to 0.
- `Tick` is ignored in IDLE.
- `req` changes during a frame are ignored. Arbitration happens only in IDLE.
- A requester whose `req` drops before its grant is not served and gets no `gnt`.
- `En` falling mid-frame has no effect on the current frame.
- `data` is sampled only in the grant cycle. Later changes do not affect the frame.

## Timing
- Reset values: `TxD`=1, `busy`=0, `gnt`=0, `done`=0, `owner`=0, `ptr`=0 (requester 0 has first priority), state IDLE, counters 0.
- Reset mid-frame: the next edge forces all reset values. `TxD` returns high immediately and no `done` pulse is issued.
- Grant latency: `req` visible in IDLE at edge n gives `gnt`, `busy`=1 and `TxD`=0 after edge n. This is combinational-free; all outputs are registered.
- Frame length: exactly 10×16 = 160 `Tick` pulses from grant to `done`. The start bit is not aligned to `Tick`, so it may be up to one `Tick` period short.
- `done` and `busy`↓ occur on the same edge.
- The earliest next `gnt` is one `Clk` after `done`. Minimum IDLE dwell is 1 cycle.
- A requester that receives `gnt` at edge n may drop `req` at edge n+1. If `req` is still high after that, it is treated as a new request.
- Simultaneous `req`: only one grant per IDLE visit. The others wait.
- A fairness bound follows from this: any continuously held request is granted within 4 frames.

## Test plan
- Reset then single request:
  - Stimulus: `req`=0001, `data[7:0]`=0xA5, `Tick` every 650 clocks.
  - Response: `gnt`=0001 for 1 cycle.
  - `TxD` sequence per 16 ticks: 0,1,0,1,0,0,1,0,1,1.
  - `done`=0001 after 160 ticks; `busy` high throughout.
- Round-robin:
  - Stimulus: `req`=1111 held, bytes 0x11/0x22/0x33/0x44.
  - Response: grant order 0,1,2,3,0.
  - Decoded stream: 0x11,0x22,0x33,0x44,0x11. Each gap between `done` and the next `gnt` is exactly 1 cycle.
- Pointer wrap:
  - Stimulus: after requester 2 is served, assert `req`=0101.
  - Response: requester 0 is skipped in favour of 2? No: `ptr`=3 wraps, so requester 0 is granted first, then 2.
- En gating:
  - Stimulus: drop `En` mid-frame with `req`=0010 pending.
  - Response: the current frame completes, then no `gnt` while `En`=0.
  - Raising `En` gives `gnt`=0010 on the next edge.
- Reset mid-DATA:
  - Stimulus: assert `Rst_n`=0 at tick 70.
  - Response: `TxD`=1, `busy`=0, no `done`, `owner`=0. After release, `req`=1000 is granted normally.
- Data/req stability:
  - Stimulus: change `data[7:0]` from 0x0F to 0xF0 one cycle after `gnt`.
  - Response: the line carries 0x0F.
  - Stimulus: drop `req[1]` before it is granted.
  - Response: no `gnt[1]`.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter. Four requesters share one TxD line.
// Bit timing comes from a 16x oversampling Tick pulse supplied by the baud-rate generator.
//
// state | meaning
// IDLE  | line high; arbitrate among req when En=1
// START | start bit (low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); done[owner] pulses at its end
module uart_tx_scheduler #(
  parameter int NREQ = 4,
  parameter int OVS  = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Tick,
  input  logic        En,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        TxD
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [3:0]  tick_cnt, tick_cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [1:0]  owner_nxt;
  logic [3:0]  gnt_nxt, done_nxt;
  logic        busy_nxt, txd_nxt;
  logic        found, bit_end;
  logic [1:0]  pick, idx;

  // First set request at or after ptr, wrapping 3 -> 0
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign bit_end = Tick && (tick_cnt == 4'(OVS - 1));

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    gnt_nxt      = 4'b0000;
    done_nxt     = 4'b0000;
    busy_nxt     = busy;
    txd_nxt      = TxD;

    if (state != IDLE && Tick) tick_cnt_nxt = tick_cnt + 4'd1;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        txd_nxt  = 1'b1;
        if (En && found) begin
          gnt_nxt      = 4'b0001 << pick;
          shift_nxt    = data[{pick, 3'b000} +: 8];
          owner_nxt    = pick;
          ptr_nxt      = pick + 2'd1;
          tick_cnt_nxt = 4'd0;
          bit_cnt_nxt  = 3'd0;
          busy_nxt     = 1'b1;
          txd_nxt      = 1'b0;
          state_nxt    = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = 3'd0;
          txd_nxt     = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            // Next bit is driven from the pre-shift value so TxD stays registered
            shift_nxt   = {1'b0, shift[7:1]};
            bit_cnt_nxt = bit_cnt + 3'd1;
            txd_nxt     = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          done_nxt  = 4'b0001 << owner;
          busy_nxt  = 1'b0;
          txd_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      shift    <= 8'h00;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      ptr      <= 2'd0;
      owner    <= 2'd0;
      gnt      <= 4'b0000;
      done     <= 4'b0000;
      busy     <= 1'b0;
      TxD      <= 1'b1;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
      TxD      <= txd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset values, framing, round-robin order, En gating,
// mid-frame reset and data/req sampling. Tick runs every 4 clocks to keep frames short.
module tb_uart_tx_scheduler;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Tick = 1'b0;
  logic        En = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] data = 32'h0;
  logic [3:0]  gnt, done;
  logic [1:0]  owner;
  logic        busy, TxD;

  int n_chk = 0;
  int n_err = 0;
  int tick_num = 0;
  int tdiv = 0;

  uart_tx_scheduler dut (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .En(En), .req(req), .data(data),
    .gnt(gnt), .done(done), .owner(owner), .busy(busy), .TxD(TxD)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    tdiv = (tdiv == 3) ? 0 : tdiv + 1;
    Tick = (tdiv == 0);
  end

  always @(posedge Clk) if (Tick) tick_num <= tick_num + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_tick(input int target);
    for (int c = 0; c < 600 && tick_num < target; c++) @(negedge Clk);
    if (tick_num < target) chk("tick_timeout", 32'(tick_num), 32'(target));
  endtask

  // Returns at the negedge where gnt is first visible; g is the tick count at the grant
  task automatic wait_gnt(input int k, input int limit, output int g);
    int c;
    c = 0;
    do begin
      @(negedge Clk);
      c++;
    end while (gnt == 4'b0000 && c < limit);
    chk("gnt", 32'(gnt), 32'(1) << k);
    chk("owner", 32'(owner), 32'(k));
    chk("busy_at_gnt", 32'(busy), 32'd1);
    chk("txd_start", 32'(TxD), 32'd0);
    g = tick_num;
  endtask

  task automatic frame(input int k, input logic [7:0] b, input int g);
    logic [9:0] exp_bits;
    logic [7:0] got;
    exp_bits = {1'b1, b, 1'b0};
    got = 8'h00;
    for (int i = 0; i < 10; i++) begin
      wait_tick(g + 16 * i + 8);
      chk("txd_bit", 32'(TxD), 32'(exp_bits[i]));
      chk("busy_frame", 32'(busy), 32'd1);
      if (i >= 1 && i <= 8) got[i-1] = TxD;
    end
    chk("done_early", 32'(done), 32'd0);
    chk("byte", 32'(got), 32'(b));
    wait_tick(g + 160);
    chk("done", 32'(done), 32'(1) << k);
    chk("busy_end", 32'(busy), 32'd0);
    chk("txd_idle", 32'(TxD), 32'd1);
  endtask

  task automatic count_gnt(input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge Clk);
      if (gnt != 4'b0000) cnt++;
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    int g, cnt;

    // Reset values
    En = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_txd", 32'(TxD), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    Rst_n = 1'b1;

    // Single request, 0xA5 -> line 0,1,0,1,0,0,1,0,1,1
    data = 32'h0000_00A5;
    req = 4'b0001;
    wait_gnt(0, 200, g);
    req = 4'b0000;
    frame(0, 8'hA5, g);

    // Round-robin with all four requesting; 1-cycle IDLE dwell between frames
    do_reset();
    data = 32'h4433_2211;
    req = 4'b1111;
    wait_gnt(0, 200, g);
    frame(0, 8'h11, g);
    wait_gnt(1, 1, g);
    frame(1, 8'h22, g);
    wait_gnt(2, 1, g);
    frame(2, 8'h33, g);
    wait_gnt(3, 1, g);
    frame(3, 8'h44, g);
    wait_gnt(0, 1, g);
    frame(0, 8'h11, g);
    req = 4'b0000;

    // Pointer wrap: after serving 2, ptr=3 so 0 precedes 2
    @(negedge Clk);
    req = 4'b0100;
    wait_gnt(2, 200, g);
    req = 4'b0000;
    frame(2, 8'h33, g);
    req = 4'b0101;
    wait_gnt(0, 200, g);
    req = 4'b0100;
    frame(0, 8'h11, g);
    wait_gnt(2, 1, g);
    req = 4'b0000;
    frame(2, 8'h33, g);

    // En dropped mid-frame with req[1] pending
    req = 4'b0001;
    wait_gnt(0, 200, g);
    req = 4'b0010;
    En = 1'b0;
    frame(0, 8'h11, g);
    count_gnt(60, cnt);
    chk("en_hold", 32'(cnt), 32'd0);
    En = 1'b1;
    wait_gnt(1, 1, g);
    req = 4'b0000;
    frame(1, 8'h22, g);

    // Reset during DATA at tick 70 of a frame for requester 2
    req = 4'b0100;
    wait_gnt(2, 200, g);
    req = 4'b0000;
    wait_tick(g + 70);
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("mid_rst_txd", 32'(TxD), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge Clk);
      if (done != 4'b0000 || TxD != 1'b1) cnt++;
    end
    chk("post_rst_quiet", 32'(cnt), 32'd0);
    data = 32'h3C33_2211;
    req = 4'b1000;
    wait_gnt(3, 200, g);
    req = 4'b0000;
    frame(3, 8'h3C, g);

    // data sampled only at grant; req[1] withdrawn before grant is never served
    data[7:0] = 8'h0F;
    req = 4'b0001;
    wait_gnt(0, 200, g);
    data[7:0] = 8'hF0;
    req = 4'b0010;
    repeat (3) @(negedge Clk);
    req = 4'b0000;
    frame(0, 8'h0F, g);
    count_gnt(60, cnt);
    chk("no_gnt1", 32'(cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
